// File: rtl/axis_pkg.sv
// Shared AXI-Stream widths and the buffered beat record used by the slave receiver.
package axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_STRB_W = 4;
  localparam int AXIS_ID_W   = 2;
  localparam int AXIS_USER_W = 2;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_STRB_W-1:0] tstrb;
    logic [AXIS_STRB_W-1:0] tkeep;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_USER_W-1:0] tuser;
    logic                   tlast;
  } axis_beat_t;

endpackage

// File: rtl/axis_rx_fifo.sv
// First-word fall-through beat buffer with pointer/occupancy bookkeeping and synchronous flush.
module axis_rx_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  axis_beat_t               wdata_i,
  output axis_beat_t               rdata_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  axis_beat_t     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop while full does not free a slot for a same-cycle push.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axis_slave.sv
// AXI-Stream slave receiver: buffers beats for a backend pop port and tracks packet length,
// backend stalls and sticky protocol errors.
module axis_slave
  import axis_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int STALL_TIMEOUT = 5,
  parameter int LEN_W         = 16
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  input  logic                   axis_tvalid,
  input  logic [AXIS_DATA_W-1:0] axis_tdata,
  input  logic [AXIS_STRB_W-1:0] axis_tstrb,
  input  logic [AXIS_STRB_W-1:0] axis_tkeep,
  input  logic                   axis_tlast,
  input  logic [AXIS_ID_W-1:0]   axis_tid,
  input  logic [AXIS_USER_W-1:0] axis_tuser,
  output logic                   axis_tready,
  output logic                   bk_valid,
  input  logic                   bk_ready,
  output logic [AXIS_DATA_W-1:0] bk_data,
  output logic [AXIS_STRB_W-1:0] bk_tstrb,
  output logic [AXIS_STRB_W-1:0] bk_tkeep,
  output logic [AXIS_ID_W-1:0]   bk_tid,
  output logic [AXIS_USER_W-1:0] bk_user,
  output logic                   bk_last,
  input  logic                   bk_flush,
  output logic                   bk_done,
  output logic [LEN_W-1:0]       bk_pkt_len,
  output logic                   bk_stall,
  output logic                   bk_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  axis_beat_t            wr_beat, head;
  logic                  full;
  logic [AW:0]           occ;
  logic                  push, pop;
  logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d, beat_inc;
  logic [LEN_W-1:0]      pkt_len_q, pkt_len_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  first_q, first_d;
  logic [AXIS_ID_W-1:0]  pkt_tid_q, pkt_tid_d;
  logic [7:0]            stall_cnt_q, stall_cnt_d;

  assign axis_tready = !full && !bk_flush && !axi_areset;
  assign bk_valid    = (occ != '0);
  assign push        = axis_tvalid && axis_tready;
  assign pop         = bk_valid && bk_ready && !bk_flush;

  assign wr_beat = '{tdata: axis_tdata, tstrb: axis_tstrb, tkeep: axis_tkeep,
                     tid: axis_tid, tuser: axis_tuser, tlast: axis_tlast};

  axis_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (axi_aclk),
    .rst_i   (axi_areset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bk_flush),
    .wdata_i (wr_beat),
    .rdata_o (head),
    .full_o  (full),
    .count_o (occ)
  );

  // Stale memory contents never leak out while the buffer is empty.
  assign bk_data  = bk_valid ? head.tdata : '0;
  assign bk_tstrb = bk_valid ? head.tstrb : '0;
  assign bk_tkeep = bk_valid ? head.tkeep : '0;
  assign bk_tid   = bk_valid ? head.tid   : '0;
  assign bk_user  = bk_valid ? head.tuser : '0;
  assign bk_last  = bk_valid ? head.tlast : 1'b0;

  assign bk_done    = done_q;
  assign bk_pkt_len = pkt_len_q;
  assign bk_err     = err_q;
  assign bk_stall   = (int'(stall_cnt_q) >= STALL_TIMEOUT);

  assign beat_inc = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + LEN_W'(1);

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    pkt_len_d   = pkt_len_q;
    done_d      = pop && head.tlast;
    err_d       = err_q;
    first_d     = first_q;
    pkt_tid_d   = pkt_tid_q;
    stall_cnt_d = stall_cnt_q;
    if (bk_flush) begin
      beat_cnt_d  = '0;
      stall_cnt_d = '0;
      err_d       = 1'b0;
      first_d     = 1'b1;
    end else begin
      if (pop) begin
        if (head.tlast) begin
          pkt_len_d  = beat_inc;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_inc;
        end
      end
      if (bk_valid && !bk_ready)
        stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
      else
        stall_cnt_d = '0;
      if (push) begin
        if (first_q) pkt_tid_d = axis_tid;
        if ((!first_q && (axis_tid != pkt_tid_q)) || (axis_tkeep == '0)) err_d = 1'b1;
        first_d = axis_tlast;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      beat_cnt_q  <= '0;
      pkt_len_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      first_q     <= 1'b1;
      pkt_tid_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      pkt_len_q   <= pkt_len_d;
      done_q      <= done_d;
      err_q       <= err_d;
      first_q     <= first_d;
      pkt_tid_q   <= pkt_tid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_slave.sv
// Directed bench for axis_slave: cycle table for short packets, hand sequences for
// backpressure, pointer wrap, protocol errors, flush and asynchronous reset.
module tb_axis_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid, tlast, tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb, tkeep;
  logic [1:0]  tid, tuser;
  logic        bk_valid, bk_ready, bk_last, bk_flush, bk_done, bk_stall, bk_err;
  logic [31:0] bk_data;
  logic [3:0]  bk_tstrb, bk_tkeep;
  logic [1:0]  bk_tid, bk_user;
  logic [15:0] bk_pkt_len;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axis_slave #(.FIFO_DEPTH(8), .STALL_TIMEOUT(5), .LEN_W(16)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .axis_tvalid(tvalid), .axis_tdata(tdata), .axis_tstrb(tstrb), .axis_tkeep(tkeep),
    .axis_tlast(tlast), .axis_tid(tid), .axis_tuser(tuser), .axis_tready(tready),
    .bk_valid(bk_valid), .bk_ready(bk_ready), .bk_data(bk_data), .bk_tstrb(bk_tstrb),
    .bk_tkeep(bk_tkeep), .bk_tid(bk_tid), .bk_user(bk_user), .bk_last(bk_last),
    .bk_flush(bk_flush), .bk_done(bk_done), .bk_pkt_len(bk_pkt_len),
    .bk_stall(bk_stall), .bk_err(bk_err)
  );

  typedef struct {
    logic        tv;
    logic [31:0] d;
    logic [3:0]  s, k;
    logic [1:0]  id, u;
    logic        l, rdy, fl;
    logic        e_trdy, e_v;
    logic [31:0] e_d;
    logic [3:0]  e_s, e_k;
    logic [1:0]  e_id, e_u;
    logic        e_l, e_done;
    logic [15:0] e_len;
    logic        e_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle for sampling.
  task automatic step(input logic tv, input logic [31:0] d, input logic [1:0] id,
                      input logic [3:0] k, input logic l, input logic rdy, input logic fl);
    @(negedge clk);
    tvalid = tv; tdata = d; tid = id; tkeep = k; tlast = l;
    tstrb = 4'hf; tuser = 2'd0; bk_ready = rdy; bk_flush = fl;
    #1;
  endtask

  // Stream n beats with the backend stalled for 12 cycles, then drain.
  task automatic run_stream(input int n, input logic [31:0] base, input string tag);
    int sent = 0, got = 0, first_v = -1, first_s = -1, tready_bad = 0, c = 0;
    for (c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      bk_ready = (c >= 12);
      bk_flush = 1'b0;
      tvalid = (sent < n);
      tdata  = base + 32'(sent);
      tlast  = (sent == n - 1);
      tid = 2'd0; tkeep = 4'hf; tstrb = 4'hf; tuser = 2'd0;
      #1;
      if (bk_valid && first_v < 0) first_v = c;
      if (bk_stall && first_s < 0) first_s = c;
      if (c == 12) begin
        chk({tag, ".full_tready"}, tready, 0);
        chk({tag, ".accepted"}, sent, 8);
      end
      if (c == 13) begin
        chk({tag, ".tready_reassert"}, tready, 1);
        chk({tag, ".stall_clear"}, bk_stall, 0);
      end
      if (c > 13 && sent < n && !tready) tready_bad++;
      if (bk_valid && bk_ready) begin
        chk($sformatf("%s.beat%0d", tag, got), bk_data, base + 32'(got));
        got++;
      end
      if (tvalid && tready) sent++;
    end
    chk({tag, ".delivered"}, got, n);
    chk({tag, ".stall_delay"}, first_s - first_v, 5);
    chk({tag, ".tready_held"}, tready_bad, 0);
    @(negedge clk);
    tvalid = 1'b0;
    #1;
    chk({tag, ".done"}, bk_done, 1);
    chk({tag, ".len"}, bk_pkt_len, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen_done;
    logic [31:0] first_pop;

    //            tv   d       s     k     id    u     l    rdy  fl  | trdy v   d       s     k     id    u     l    done len    err
    vecs[0]  = '{1'b1,32'h11,4'h1,4'hf,2'd1,2'd1,1'b0,1'b1,1'b0, 1'b1,1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b0,16'd0,1'b0};
    vecs[1]  = '{1'b1,32'h22,4'h3,4'he,2'd1,2'd2,1'b0,1'b1,1'b0, 1'b1,1'b1,32'h11,4'h1,4'hf,2'd1,2'd1,1'b0,1'b0,16'd0,1'b0};
    vecs[2]  = '{1'b1,32'h33,4'h7,4'hc,2'd1,2'd3,1'b1,1'b1,1'b0, 1'b1,1'b1,32'h22,4'h3,4'he,2'd1,2'd2,1'b0,1'b0,16'd0,1'b0};
    vecs[3]  = '{1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,1'b0, 1'b1,1'b1,32'h33,4'h7,4'hc,2'd1,2'd3,1'b1,1'b0,16'd0,1'b0};
    vecs[4]  = '{1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,1'b0, 1'b1,1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,16'd3,1'b0};
    vecs[5]  = '{1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,1'b0, 1'b1,1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b0,16'd3,1'b0};
    vecs[6]  = '{1'b1,32'h44,4'hf,4'hf,2'd0,2'd0,1'b1,1'b1,1'b0, 1'b1,1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b0,16'd3,1'b0};
    vecs[7]  = '{1'b1,32'h55,4'h8,4'h8,2'd2,2'd1,1'b1,1'b1,1'b0, 1'b1,1'b1,32'h44,4'hf,4'hf,2'd0,2'd0,1'b1,1'b0,16'd3,1'b0};
    vecs[8]  = '{1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,1'b0, 1'b1,1'b1,32'h55,4'h8,4'h8,2'd2,2'd1,1'b1,1'b1,16'd1,1'b0};
    vecs[9]  = '{1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,1'b0, 1'b1,1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,16'd1,1'b0};
    vecs[10] = '{1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,1'b0, 1'b1,1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b0,16'd1,1'b0};
    vecs[11] = '{1'b1,32'h66,4'hf,4'hf,2'd0,2'd0,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b0,16'd1,1'b0};
    vecs[12] = '{1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b1,1'b0, 1'b1,1'b0,32'h0 ,4'h0,4'h0,2'd0,2'd0,1'b0,1'b0,16'd1,1'b0};

    rst = 1'b1;
    tvalid = 1'b0; tdata = '0; tstrb = '0; tkeep = '0; tlast = 1'b0; tid = '0; tuser = '0;
    bk_ready = 1'b0; bk_flush = 1'b0;
    #12;
    chk("rst.tready", tready, 0);
    chk("rst.valid", bk_valid, 0);
    chk("rst.done", bk_done, 0);
    chk("rst.len", bk_pkt_len, 0);
    chk("rst.stall", bk_stall, 0);
    chk("rst.err", bk_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Three-beat packet, then two back-to-back single-beat packets, then a flush cycle.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      tvalid = vecs[i].tv; tdata = vecs[i].d; tstrb = vecs[i].s; tkeep = vecs[i].k;
      tid = vecs[i].id; tuser = vecs[i].u; tlast = vecs[i].l;
      bk_ready = vecs[i].rdy; bk_flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d.tready", i), tready, vecs[i].e_trdy);
      chk($sformatf("v%0d.valid", i), bk_valid, vecs[i].e_v);
      chk($sformatf("v%0d.data", i), bk_data, vecs[i].e_d);
      chk($sformatf("v%0d.tstrb", i), bk_tstrb, vecs[i].e_s);
      chk($sformatf("v%0d.tkeep", i), bk_tkeep, vecs[i].e_k);
      chk($sformatf("v%0d.tid", i), bk_tid, vecs[i].e_id);
      chk($sformatf("v%0d.user", i), bk_user, vecs[i].e_u);
      chk($sformatf("v%0d.last", i), bk_last, vecs[i].e_l);
      chk($sformatf("v%0d.done", i), bk_done, vecs[i].e_done);
      chk($sformatf("v%0d.len", i), bk_pkt_len, vecs[i].e_len);
      chk($sformatf("v%0d.err", i), bk_err, vecs[i].e_err);
    end

    run_stream(10, 32'h100, "bp10");
    run_stream(24, 32'h200, "wrap24");

    // Protocol errors, stickiness and flush.
    step(1'b1, 32'hC1, 2'd1, 4'hf, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 2'd2, 4'hf, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 2'd0, 4'hf, 1'b0, 1'b0, 1'b0);
    chk("tid_err", bk_err, 1);
    chk("tid_err.valid", bk_valid, 1);
    step(1'b0, 32'h0, 2'd0, 4'hf, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", bk_err, 1);
    step(1'b1, 32'hC3, 2'd0, 4'hf, 1'b0, 1'b0, 1'b1);
    chk("flush.tready", tready, 0);
    step(1'b0, 32'h0, 2'd0, 4'hf, 1'b0, 1'b0, 1'b0);
    chk("flush.valid", bk_valid, 0);
    chk("flush.err", bk_err, 0);
    chk("flush.tready_after", tready, 1);
    chk("flush.len_held", bk_pkt_len, 24);
    step(1'b1, 32'hC4, 2'd3, 4'hf, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC5, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("first_after_flush", bk_err, 0);
    step(1'b0, 32'h0, 2'd0, 4'hf, 1'b0, 1'b0, 1'b0);
    chk("keep0_err", bk_err, 1);
    step(1'b0, 32'h0, 2'd0, 4'hf, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 2'd0, 4'hf, 1'b0, 1'b0, 1'b0);
    chk("flush2.err", bk_err, 0);
    chk("flush2.valid", bk_valid, 0);

    // Asynchronous reset with four beats buffered mid-packet.
    step(1'b1, 32'hA0, 2'd3, 4'hf, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA1, 2'd3, 4'hf, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 2'd3, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA3, 2'd3, 4'hf, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 2'd0, 4'hf, 1'b0, 1'b0, 1'b0);
    chk("pre_rst.stall", bk_stall, 1);
    chk("pre_rst.err", bk_err, 1);
    chk("pre_rst.data", bk_data, 32'hA0);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", bk_valid, 0);
    chk("arst.data", bk_data, 0);
    chk("arst.tready", tready, 0);
    chk("arst.stall", bk_stall, 0);
    chk("arst.err", bk_err, 0);
    chk("arst.len", bk_pkt_len, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'hB0, 2'd1, 4'hf, 1'b0, 1'b1, 1'b0);
    chk("post_rst.empty", bk_valid, 0);
    step(1'b1, 32'hB1, 2'd1, 4'hf, 1'b1, 1'b1, 1'b0);
    first_pop = bk_data;
    chk("post_rst.head", first_pop, 32'hB0);
    seen_done = 0;
    for (int i = 0; i < 10 && seen_done == 0; i++) begin
      step(1'b0, 32'h0, 2'd0, 4'hf, 1'b0, 1'b1, 1'b0);
      if (bk_done) seen_done = 1;
    end
    chk("post_rst.done_seen", seen_done, 1);
    chk("post_rst.len", bk_pkt_len, 2);
    chk("post_rst.err", bk_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
